// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-ported memory between instruction fetch and
// load/store, with data-first priority and a starvation guard for fetch.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read_write,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy
);

  localparam int unsigned WAIT_W   = $clog2(MEM_LAT + 1);
  localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_owner_d;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_we;
  logic [DATA_W-1:0]   r_wdata;
  logic [WAIT_W-1:0]   r_wait;
  logic [STARVE_W-1:0] r_starve;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_d_rdata;
  logic                r_if_done;
  logic                r_d_done;
  logic                r_mem_en;
  logic                r_busy;

  state_t              w_state_nxt;
  logic                w_grant_d;
  logic                w_owner_d_nxt;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic                w_we_nxt;
  logic [DATA_W-1:0]   w_wdata_nxt;
  logic [WAIT_W-1:0]   w_wait_nxt;
  logic [STARVE_W-1:0] w_starve_nxt;
  logic [DATA_W-1:0]   w_if_rdata_nxt;
  logic [DATA_W-1:0]   w_d_rdata_nxt;
  logic                w_if_done_nxt;
  logic                w_d_done_nxt;
  logic                w_mem_en_nxt;
  logic                w_busy_nxt;

  // Next-state, request latching and registered-output decode
  always_comb begin
    w_state_nxt    = r_state;
    w_grant_d      = 1'b0;
    w_owner_d_nxt  = r_owner_d;
    w_addr_nxt     = r_addr;
    w_we_nxt       = r_we;
    w_wdata_nxt    = r_wdata;
    w_wait_nxt     = r_wait;
    w_starve_nxt   = r_starve;
    w_if_rdata_nxt = r_if_rdata;
    w_d_rdata_nxt  = r_d_rdata;

    case (r_state)
      S_IDLE: begin
        if (if_req || d_req) begin
          // Data wins ties unless fetch has lost STARVE_MAX arbitrations in a row
          w_grant_d     = d_req && !(if_req && (r_starve == STARVE_W'(STARVE_MAX)));
          w_state_nxt   = S_ACCESS;
          w_owner_d_nxt = w_grant_d;
          w_addr_nxt    = w_grant_d ? d_addr : if_addr;
          w_we_nxt      = w_grant_d & d_we;
          w_wdata_nxt   = w_grant_d ? d_wdata : '0;
          w_wait_nxt    = '0;
          if (!w_grant_d) begin
            w_starve_nxt = '0;
          end else if (if_req && (r_starve != STARVE_W'(STARVE_MAX))) begin
            w_starve_nxt = r_starve + STARVE_W'(1);
          end
        end
      end
      S_ACCESS: begin
        w_wait_nxt = r_wait + WAIT_W'(1);
        if (r_wait == WAIT_W'(MEM_LAT - 1)) begin
          w_state_nxt = S_DONE;
          if (!r_we) begin
            if (r_owner_d) begin
              w_d_rdata_nxt = mem_data_out;
            end else begin
              w_if_rdata_nxt = mem_data_out;
            end
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_mem_en_nxt  = (w_state_nxt == S_ACCESS);
    w_busy_nxt    = (w_state_nxt != S_IDLE);
    w_if_done_nxt = (w_state_nxt == S_DONE) && !w_owner_d_nxt;
    w_d_done_nxt  = (w_state_nxt == S_DONE) && w_owner_d_nxt;
  end

  // State and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_owner_d  <= 1'b0;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
      r_wait     <= '0;
      r_starve   <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
      r_if_done  <= 1'b0;
      r_d_done   <= 1'b0;
      r_mem_en   <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner_d  <= w_owner_d_nxt;
      r_addr     <= w_addr_nxt;
      r_we       <= w_we_nxt;
      r_wdata    <= w_wdata_nxt;
      r_wait     <= w_wait_nxt;
      r_starve   <= w_starve_nxt;
      r_if_rdata <= w_if_rdata_nxt;
      r_d_rdata  <= w_d_rdata_nxt;
      r_if_done  <= w_if_done_nxt;
      r_d_done   <= w_d_done_nxt;
      r_mem_en   <= w_mem_en_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  assign if_rdata       = r_if_rdata;
  assign if_done        = r_if_done;
  assign d_rdata        = r_d_rdata;
  assign d_done         = r_d_done;
  assign mem_en         = r_mem_en;
  assign mem_addr       = r_addr;
  assign mem_read_write = r_we;
  assign mem_data_in    = r_wdata;
  assign busy           = r_busy;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported memory between the instruction-fetch requester and the load/store requester of the five-stage core. It sits between the pipeline's fetch/memory stages and a unified memory with fixed read latency. It arbitrates with data-first priority and an anti-starvation counter for fetch, and sequences each access through issue, wait and response. Every access completes with a one-cycle done pulse to the owning requester.

## Interface
Parameters:
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width.
- `MEM_LAT`, 2, memory cycles from issue to valid `mem_data_out`; must be ≥1.
- `STARVE_MAX`, 4, number of consecutive lost arbitrations after which fetch is granted unconditionally; must be ≥1.

Ports:
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high.
- `if_req`  in  1  fetch request; held high, with `if_addr` stable, until `if_done`.
- `if_addr`  in  ADDR_W  fetch address.
- `if_rdata`  out  DATA_W  fetched instruction; valid while `if_done`=1 and held until the next fetch completes.
- `if_done`  out  1  one-cycle completion pulse for fetch.
- `d_req`  in  1  data request; held high, with `d_we`/`d_addr`/`d_wdata` stable, until `d_done`.
- `d_we`  in  1  1=store, 0=load.
- `d_addr`  in  ADDR_W  data address.
- `d_wdata`  in  DATA_W  store data.
- `d_rdata`  out  DATA_W  load data; held until the next load completes. Stores leave it unchanged.
- `d_done`  out  1  one-cycle completion pulse for data.
- `mem_en`  out  1  memory access active.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_read_write`  out  1  1=write, 0=read.
- `mem_data_in`  out  DATA_W  memory write data.
- `mem_data_out`  in  DATA_W  memory read data.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states and transitions:
  - IDLE → ACCESS when a request is granted.
  - ACCESS → DONE after exactly `MEM_LAT` cycles.
  - DONE → IDLE unconditionally.
- Requests are sampled only in IDLE. A request arriving in any other state waits.
- Arbitration in IDLE:
  - Only one request high: grant it.
  - Both high: grant data, unless `starve_cnt` == `STARVE_MAX`, in which case grant fetch.
- `starve_cnt` update:
  - Increments, saturating at `STARVE_MAX`, whenever fetch requests in IDLE and data is granted.
  - Clears to 0 whenever fetch is granted.
  - Otherwise holds.
- On grant, latch owner, address, `we` and `wdata` into registers. All `mem_*` outputs come from these latches, never from requester inputs directly.
- Fetch accesses always drive `mem_read_write`=0.
- In ACCESS, `mem_en`=1. `mem_addr`, `mem_read_write` and `mem_data_in` are held constant for all `MEM_LAT` cycles.
- Wait counter width is $clog2(MEM_LAT+1). It is loaded with 0 on grant and increments each ACCESS cycle.
- At the edge ending the `MEM_LAT`-th ACCESS cycle:
  - Read access: capture `mem_data_out` into the owner's rdata register.
  - Write access: capture nothing.
- In DONE, the owner's done output is 1 and the other port's done output is 0.
- Requester protocol: drop or replace the request at the edge ending DONE. A request still high in the following IDLE cycle is treated as a new request.
- Simultaneous `if_done` and `d_done` is impossible. Verification asserts `if_done & d_done` == 0.

## Timing
- Reset values: state=IDLE, `starve_cnt`=0, `mem_en`=0, `mem_addr`=0, `mem_read_write`=0, `mem_data_in`=0, `if_rdata`=0, `d_rdata`=0, `if_done`=0, `d_done`=0, `busy`=0.
- Reset is asynchronous: all outputs clear immediately on assertion. Reset asserted mid-ACCESS or mid-DONE aborts the access, and no done pulse is ever produced for it.
- Latency: request sampled at edge E0 gives ACCESS for cycles E0+1 through E0+`MEM_LAT`, and done high in cycle E0+`MEM_LAT`+1.
- Back-to-back requests on one port: done pulses are spaced `MEM_LAT`+2 cycles apart (one IDLE bubble).
- Throughput: at most one access per `MEM_LAT`+2 cycles.

## Test plan
- Reset: assert `reset` with random inputs → all outputs 0 asynchronously, `busy`=0. Hold `reset` for 3 cycles → outputs remain 0.
- Single fetch (`MEM_LAT`=2): `if_req`=1, `if_addr`=0x100; memory returns 0x00500093 → `mem_en`=1 with `mem_addr`=0x100 and `mem_read_write`=0 for 2 cycles, `if_done` pulses at E0+3, `if_rdata`=0x00500093.
- Store: `d_req`=1, `d_we`=1, `d_addr`=0x2000, `d_wdata`=0xDEADBEEF → `mem_read_write`=1 and `mem_data_in`=0xDEADBEEF for 2 cycles, `d_done` pulses once, `d_rdata` unchanged.
- Contention (`STARVE_MAX`=4): `if_req` and `d_req` both held high, each re-raised after its done → grant order D,D,D,D,I,D,D,D,D,I, and `if_done & d_done` never both 1.
- Reset mid-access: assert `reset` in the 2nd ACCESS cycle of a load, release, then re-raise the same load → no `d_done` for the aborted access, and the reissued load completes at E0+3 with correct data.
- Back-to-back fetches at 0x0 and 0x4 → `if_done` pulses 4 cycles apart, `if_rdata` matches each address.
